mux_key_demux: RTL and testbench

- Keyed demultiplexer: the write-side counterpart of the team's key-lookup mux.
- Accepts a stream of (key, data) beats on a valid/ready input and matches the key against a run-time key table.
- Delivers each data word into the one-entry output register of the matching lane. Unmatched keys go to a default lane or are dropped.
- Sits between a single producer (e.g. switch/keyboard decode) and NR_KEY independent consumers.

---
 rtl/mux_key_demux.sv | 126 ++++++++++++
 tb/tb_mux_key_demux.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_demux.sv
// Keyed demultiplexer: routes each (key, data) beat to the lowest-index lane whose table key matches, else to the default lane or drop.
// Latency 1 cycle into a one-entry lane register; in_ready falls only when the beat's own target lane is full and not draining.
module mux_key_demux #(
   parameter int NR_KEY      = 4,
   parameter int KEY_LEN     = 2,
   parameter int DATA_LEN    = 2,
   parameter int HAS_DEFAULT = 1,
   parameter int CNT_LEN     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NR_KEY*KEY_LEN-1:0]    key_table,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [KEY_LEN-1:0]           in_key,
   input  logic [DATA_LEN-1:0]          in_data,
   output logic [NR_KEY-1:0]            out_valid,
   input  logic [NR_KEY-1:0]            out_ready,
   output logic [NR_KEY*DATA_LEN-1:0]   out_data,
   output logic                         def_valid,
   input  logic                         def_ready,
   output logic [KEY_LEN-1:0]           def_key,
   output logic [DATA_LEN-1:0]          def_data,
   output logic [CNT_LEN-1:0]           miss_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_st_t;

   localparam logic [CNT_LEN-1:0] CNT_MAX = '1;
   localparam logic [CNT_LEN-1:0] CNT_ONE = {{(CNT_LEN-1){1'b0}}, 1'b1};

   lane_st_t                       lane_st_q [NR_KEY];
   lane_st_t                       lane_st_d [NR_KEY];
   lane_st_t                       def_st_q, def_st_d;
   logic [NR_KEY*DATA_LEN-1:0]     out_data_q, out_data_d;
   logic [KEY_LEN-1:0]             def_key_q, def_key_d;
   logic [DATA_LEN-1:0]            def_data_q, def_data_d;
   logic [CNT_LEN-1:0]             miss_cnt_q, miss_cnt_d;

   logic [NR_KEY-1:0]              hit_oh;
   logic [NR_KEY-1:0]              lane_free;
   logic [NR_KEY-1:0]              lane_load;
   logic                           hit;
   logic                           def_free;
   logic                           accept;
   logic                           def_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int n = 0; n < NR_KEY; n++) lane_st_q[n] <= EMPTY;
         def_st_q   <= EMPTY;
         out_data_q <= '0;
         def_key_q  <= '0;
         def_data_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         for (int n = 0; n < NR_KEY; n++) lane_st_q[n] <= lane_st_d[n];
         def_st_q   <= def_st_d;
         out_data_q <= out_data_d;
         def_key_q  <= def_key_d;
         def_data_q <= def_data_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Descending scan so the lowest matching index overwrites any higher one.
   always_comb begin
      hit_oh = '0;
      hit    = 1'b0;
      for (int n = NR_KEY - 1; n >= 0; n--) begin
         if (key_table[n*KEY_LEN +: KEY_LEN] == in_key) begin
            hit_oh    = '0;
            hit_oh[n] = 1'b1;
            hit       = 1'b1;
         end
      end
      lane_free = ~out_valid | out_ready;
      def_free  = !def_valid || def_ready;
      if (hit)
         in_ready = |(hit_oh & lane_free);
      else if (HAS_DEFAULT != 0)
         in_ready = def_free;
      else
         in_ready = 1'b1;
      accept    = in_valid && in_ready;
      lane_load = accept ? hit_oh : '0;
      def_load  = accept && !hit && (HAS_DEFAULT != 0);
   end

   always_comb begin
      for (int n = 0; n < NR_KEY; n++) begin
         lane_st_d[n] = lane_st_q[n];
         case (lane_st_q[n])
            EMPTY:   lane_st_d[n] = lane_load[n] ? FULL : EMPTY;
            FULL:    lane_st_d[n] = (lane_load[n] || !out_ready[n]) ? FULL : EMPTY;
            default: lane_st_d[n] = EMPTY;
         endcase
      end
      def_st_d = def_st_q;
      case (def_st_q)
         EMPTY:   def_st_d = def_load ? FULL : EMPTY;
         FULL:    def_st_d = (def_load || !def_ready) ? FULL : EMPTY;
         default: def_st_d = EMPTY;
      endcase

      out_data_d = out_data_q;
      for (int n = 0; n < NR_KEY; n++) begin
         if (lane_load[n]) out_data_d[n*DATA_LEN +: DATA_LEN] = in_data;
      end
      def_key_d  = def_load ? in_key  : def_key_q;
      def_data_d = def_load ? in_data : def_data_q;
      miss_cnt_d = miss_cnt_q;
      if (accept && !hit && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + CNT_ONE;
   end

   always_comb begin
      out_valid = '0;
      for (int n = 0; n < NR_KEY; n++) out_valid[n] = (lane_st_q[n] == FULL);
      def_valid = (def_st_q == FULL);
      out_data  = out_data_q;
      def_key   = def_key_q;
      def_data  = def_data_q;
      miss_cnt  = miss_cnt_q;
   end

endmodule

// File: tb/tb_mux_key_demux.sv
// Bench for mux_key_demux: default-lane instance with a queue scoreboard, plus a drop-mode instance with a 2-bit miss counter.
module tb_mux_key_demux;
   localparam int NK = 4;
   localparam int KL = 2;
   localparam int DL = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [NK*KL-1:0] key_table;
   logic            in_valid, in_ready;
   logic [KL-1:0]   in_key;
   logic [DL-1:0]   in_data;
   logic [NK-1:0]   out_valid, out_ready;
   logic [NK*DL-1:0] out_data;
   logic            def_valid, def_ready;
   logic [KL-1:0]   def_key;
   logic [DL-1:0]   def_data;
   logic [7:0]      miss_cnt;

   logic [NK*KL-1:0] key_table0;
   logic            in0_valid, in_ready0;
   logic [KL-1:0]   in0_key;
   logic [DL-1:0]   in0_data;
   logic [NK-1:0]   out_valid0;
   logic [NK*DL-1:0] out_data0;
   logic            def_valid0;
   logic [KL-1:0]   def_key0;
   logic [DL-1:0]   def_data0;
   logic [1:0]      miss_cnt0;

   mux_key_demux #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1), .CNT_LEN(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .key_table(key_table),
      .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .def_valid(def_valid), .def_ready(def_ready), .def_key(def_key), .def_data(def_data),
      .miss_cnt(miss_cnt)
   );

   mux_key_demux #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(0), .CNT_LEN(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .key_table(key_table0),
      .in_valid(in0_valid), .in_ready(in_ready0), .in_key(in0_key), .in_data(in0_data),
      .out_valid(out_valid0), .out_ready(4'b1111), .out_data(out_data0),
      .def_valid(def_valid0), .def_ready(1'b0), .def_key(def_key0), .def_data(def_data0),
      .miss_cnt(miss_cnt0)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic int lookup(input logic [NK*KL-1:0] tbl, input logic [KL-1:0] k);
      for (int n = 0; n < NK; n++) begin
         if (((tbl >> (KL*n)) & 8'h3) == {6'd0, k}) return n;
      end
      return -1;
   endfunction

   typedef struct packed {logic [KL-1:0] k; logic [DL-1:0] d;} db_t;

   // Reference model: each lane is a queue of pending words; depth never exceeds one.
   logic [DL-1:0] lane_q [NK][$];
   db_t           def_q [$];
   logic [DL-1:0] last_dat [NK];
   db_t           last_def;
   int            miss_m;

   initial begin
      int t;
      bit exp_rdy;
      logic [NK-1:0] exp_vld;
      logic [NK*DL-1:0] exp_dat;
      db_t exp_def;
      for (int n = 0; n < NK; n++) last_dat[n] = '0;
      last_def = '0;
      miss_m   = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         t = lookup(key_table, in_key);
         if (t >= 0) exp_rdy = (lane_q[t].size() == 0) || out_ready[t];
         else        exp_rdy = (def_q.size() == 0) || def_ready;
         exp_vld = '0;
         exp_dat = '0;
         for (int n = 0; n < NK; n++) begin
            exp_vld[n] = (lane_q[n].size() != 0);
            exp_dat[n*DL +: DL] = exp_vld[n] ? lane_q[n][0] : last_dat[n];
         end
         exp_def = (def_q.size() != 0) ? def_q[0] : last_def;
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("out_valid", {28'd0, out_valid}, {28'd0, exp_vld});
         chk("out_data", {24'd0, out_data}, {24'd0, exp_dat});
         chk("def_valid", {31'd0, def_valid}, (def_q.size() != 0) ? 32'd1 : 32'd0);
         chk("def_key_data", {28'd0, def_key, def_data}, {28'd0, exp_def});
         chk("miss_cnt", {24'd0, miss_cnt}, miss_m);
         if (!rst_n) begin
            for (int n = 0; n < NK; n++) begin
               lane_q[n].delete();
               last_dat[n] = '0;
            end
            def_q.delete();
            last_def = '0;
            miss_m   = 0;
         end else begin
            for (int n = 0; n < NK; n++)
               if (lane_q[n].size() != 0 && out_ready[n]) void'(lane_q[n].pop_front());
            if (def_q.size() != 0 && def_ready) void'(def_q.pop_front());
            if (in_valid && exp_rdy) begin
               if (t >= 0) begin
                  lane_q[t].push_back(in_data);
                  last_dat[t] = in_data;
               end else begin
                  def_q.push_back({in_key, in_data});
                  last_def = {in_key, in_data};
                  miss_m   = (miss_m < 255) ? miss_m + 1 : 255;
               end
            end
         end
      end
   end

   // Drop-mode model: lanes always drain, so occupancy is just "loaded last cycle".
   initial begin
      int t;
      logic [NK-1:0] occ0;
      logic [NK*DL-1:0] last0;
      int miss0;
      occ0  = '0;
      last0 = '0;
      miss0 = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("in_ready0", {31'd0, in_ready0}, 32'd1);
         chk("out_valid0", {28'd0, out_valid0}, {28'd0, occ0});
         chk("out_data0", {24'd0, out_data0}, {24'd0, last0});
         chk("def0_idle", {27'd0, def_valid0, def_key0, def_data0}, 32'd0);
         chk("miss_cnt0", {30'd0, miss_cnt0}, miss0);
         if (!rst_n) begin
            occ0  = '0;
            last0 = '0;
            miss0 = 0;
         end else begin
            occ0 = '0;
            t = lookup(key_table0, in0_key);
            if (in0_valid && t >= 0) begin
               occ0[t] = 1'b1;
               last0[t*DL +: DL] = in0_data;
            end else if (in0_valid) begin
               miss0 = (miss0 < 3) ? miss0 + 1 : 3;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [KL-1:0] k, input logic [DL-1:0] d);
      int n;
      bit done;
      n = 0;
      done = 0;
      in_valid = 1'b1;
      in_key   = k;
      in_data  = d;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 40) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat key=%0d not accepted after %0d cycles, required acceptance", k, n);
            done = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      key_table  = {2'd3, 2'd2, 2'd1, 2'd0};
      in_valid   = 1'b0;
      in_key     = '0;
      in_data    = '0;
      out_ready  = '1;
      def_ready  = 1'b1;
      key_table0 = '0;
      in0_valid  = 1'b0;
      in0_key    = '0;
      in0_data   = '0;
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Drop mode: five unmatched beats back to back, then one matched.
      in0_valid = 1'b1;
      in0_key   = 2'd3;
      in0_data  = 2'd1;
      idle(5);
      in0_key  = 2'd0;
      in0_data = 2'd2;
      idle(1);
      in0_valid = 1'b0;
      idle(2);

      send(2'd2, 2'b10);
      idle(2);

      out_ready = 4'b1101;
      send(2'd1, 2'b01);
      fork
         send(2'd1, 2'b11);
         begin
            idle(4);
            out_ready[1] = 1'b1;
         end
      join
      idle(2);

      key_table = {2'd3, 2'd2, 2'd1, 2'd1};
      send(2'd1, 2'b11);
      idle(2);

      key_table = '0;
      def_ready = 1'b0;
      send(2'd3, 2'b10);
      in_valid = 1'b1;
      in_key   = 2'd2;
      in_data  = 2'b01;
      idle(3);
      send(2'd0, 2'b11);
      def_ready = 1'b1;
      idle(2);

      for (int i = 0; i < 600; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_key    = 2'($urandom);
         in_data   = 2'($urandom);
         out_ready = 4'($urandom);
         def_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) key_table = 8'($urandom);
         in0_valid = 1'($urandom_range(0, 1));
         in0_key   = 2'($urandom);
         in0_data  = 2'($urandom);
         idle(1);
      end
      in_valid  = 1'b0;
      in0_valid = 1'b0;
      out_ready = '1;
      def_ready = 1'b1;
      idle(2);

      key_table = '0;
      in_valid  = 1'b1;
      in_key    = 2'd3;
      for (int i = 0; i < 300; i++) begin
         in_data = 2'($urandom);
         idle(1);
      end
      in_valid = 1'b0;
      idle(2);

      key_table = {2'd3, 2'd2, 2'd1, 2'd0};
      out_ready = '0;
      send(2'd0, 2'b01);
      send(2'd3, 2'b10);
      idle(1);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_key   = 2'd1;
      in_data  = 2'b11;
      idle(1);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      idle(3);
      out_ready = '1;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
